// File: rtl/knn_vote.sv
// knn_vote: majority vote over the K nearest type labels from distance_sort.
// type_array_sorted is flattened with entry i at bits [i*TYPE_W +: TYPE_W].
module knn_vote #(
  parameter int N      = 100,
  parameter int K      = 5,
  parameter int TYPE_W = 3,
  parameter int CW     = $clog2(K + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_sort,
  input  logic [N*TYPE_W-1:0]   type_array_sorted,
  output logic [TYPE_W-1:0]     class_out,
  output logic [CW-1:0]         vote_count,
  output logic                  knn_valid,
  output logic                  busy
);

  localparam int C  = 1 << TYPE_W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    IDLE, COUNT, SCAN, DONE, RESP
  } state_t;

  state_t            state_q, state_d;
  logic              vs_q;
  logic [TYPE_W-1:0] lab_q [K];
  logic [TYPE_W-1:0] lab_d [K];
  logic [CW-1:0]     cnt_q [C];
  logic [CW-1:0]     cnt_d [C];
  logic [IW-1:0]     first_q [C];
  logic [IW-1:0]     first_d [C];
  logic [IW-1:0]     idx_q, idx_d;
  logic [TYPE_W-1:0] sc_q, sc_d;
  logic [TYPE_W-1:0] best_q, best_d;
  logic [CW-1:0]     bcnt_q, bcnt_d;
  logic [TYPE_W-1:0] class_q, class_d;
  logic [CW-1:0]     vcnt_q, vcnt_d;
  logic [TYPE_W-1:0] lbl;
  logic              start;
  logic              take;

  if (K < N) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^type_array_sorted[N*TYPE_W-1:K*TYPE_W];
  end

  always_comb begin
    state_d = state_q;
    lab_d   = lab_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    idx_d   = idx_q;
    sc_d    = sc_q;
    best_d  = best_q;
    bcnt_d  = bcnt_q;
    class_d = class_q;
    vcnt_d  = vcnt_q;
    lbl     = lab_q[idx_q];
    start   = (state_q == IDLE) && valid_sort && !vs_q;
    take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < K; i++)
            lab_d[i] = type_array_sorted[i*TYPE_W +: TYPE_W];
          for (int c = 0; c < C; c++) begin
            cnt_d[c]   = '0;
            first_d[c] = '0;
          end
          idx_d   = '0;
          sc_d    = '0;
          best_d  = '0;
          bcnt_d  = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (lbl != '0 && cnt_q[lbl] != CW'(K)) begin
          cnt_d[lbl] = cnt_q[lbl] + 1'b1;
          if (cnt_q[lbl] == '0)
            first_d[lbl] = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(K - 1))
          state_d = SCAN;
      end
      SCAN: begin
        // Ties go to the class whose first vote is nearest.
        take = (sc_q != '0) &&
               ((cnt_q[sc_q] > bcnt_q) ||
                (cnt_q[sc_q] == bcnt_q && cnt_q[sc_q] != '0 &&
                 first_q[sc_q] < first_q[best_q]));
        if (take) begin
          best_d = sc_q;
          bcnt_d = cnt_q[sc_q];
        end
        sc_d = sc_q + 1'b1;
        if (sc_q == TYPE_W'(C - 1))
          state_d = DONE;
      end
      DONE: begin
        class_d = best_q;
        vcnt_d  = bcnt_q;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      for (int i = 0; i < K; i++)
        lab_q[i] <= '0;
      for (int c = 0; c < C; c++) begin
        cnt_q[c]   <= '0;
        first_q[c] <= '0;
      end
      idx_q   <= '0;
      sc_q    <= '0;
      best_q  <= '0;
      bcnt_q  <= '0;
      class_q <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= valid_sort;
      lab_q   <= lab_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      idx_q   <= idx_d;
      sc_q    <= sc_d;
      best_q  <= best_d;
      bcnt_q  <= bcnt_d;
      class_q <= class_d;
      vcnt_q  <= vcnt_d;
    end
  end

  assign class_out  = class_q;
  assign vote_count = vcnt_q;
  assign knn_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed and random votes against a counting model.
// Checks latency, busy length, pulse count, result and reset behaviour.
module tb_knn_vote;

  localparam int N  = 100;
  localparam int K  = 5;
  localparam int TW = 3;
  localparam int CW = 3;

  logic              clk;
  logic              rst;
  logic              valid_sort;
  logic [N*TW-1:0]   tas;
  logic [TW-1:0]     class_out;
  logic [CW-1:0]     vote_count;
  logic              knn_valid;
  logic              busy;

  int n_assert;
  int n_fail;

  knn_vote #(.N(N), .K(K), .TYPE_W(TW)) dut (
    .clk               (clk),
    .rst               (rst),
    .valid_sort        (valid_sort),
    .type_array_sorted (tas),
    .class_out         (class_out),
    .vote_count        (vote_count),
    .knn_valid         (knn_valid),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Winner: among labels with the top count, the one appearing earliest.
  function automatic void model(input int l[K], output int cls,
                                output int cnt);
    int m, occ;
    m = 0; cls = 0;
    for (int i = 0; i < K; i++) begin
      occ = 0;
      for (int j = 0; j < K; j++)
        if (l[i] != 0 && l[j] == l[i]) occ++;
      if (occ > m) m = occ;
    end
    for (int i = 0; i < K; i++) begin
      occ = 0;
      for (int j = 0; j < K; j++)
        if (l[i] != 0 && l[j] == l[i]) occ++;
      if (cls == 0 && m > 0 && occ == m) cls = l[i];
    end
    cnt = m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int l[K]);
    for (int i = 0; i < N; i++)
      tas[i*TW +: TW] = (i < K) ? TW'(l[i]) : TW'($urandom);
  endtask

  task automatic do_vote(input int l[K], input string tag);
    int ec, en, lat, bc, np;
    logic [TW-1:0] oc;
    logic [CW-1:0] on;
    model(l, ec, en);
    load(l);
    valid_sort = 1'b1;
    lat = -1; bc = 0; np = 0; oc = '0; on = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy) bc++;
      if (knn_valid) begin
        np++;
        if (lat < 0) begin
          lat = i; oc = class_out; on = vote_count;
        end
      end
    end
    valid_sort = 1'b0;
    tick();
    chk({tag, "_lat"}, lat, 14);
    chk({tag, "_busy"}, bc, 15);
    chk({tag, "_pulses"}, np, 1);
    chk({tag, "_class"}, oc, ec);
    chk({tag, "_count"}, on, en);
    chk({tag, "_hold"}, class_out, ec);
  endtask

  initial begin
    int r[K];
    int np;
    n_assert = 0;
    n_fail = 0;
    rst = 1'b0;
    valid_sort = 1'b0;
    tas = '0;
    #1;
    chk("rst_class", class_out, 0);
    chk("rst_count", vote_count, 0);
    chk("rst_valid", knn_valid, 0);
    chk("rst_busy", busy, 0);
    #22;
    rst = 1'b1;
    tick();

    do_vote('{3, 3, 1, 2, 3}, "major");
    do_vote('{2, 4, 4, 2, 5}, "tie_a");
    do_vote('{4, 2, 2, 4, 1}, "tie_b");
    do_vote('{0, 0, 0, 0, 0}, "zeros");
    do_vote('{0, 0, 5, 0, 1}, "zero_mix");
    do_vote('{7, 7, 7, 7, 7}, "all_same");

    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < K; i++)
        r[i] = (v < 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
      do_vote(r, $sformatf("rand%0d", v));
    end

    // Re-pulse during busy and input change during COUNT.
    load('{3, 3, 1, 2, 3});
    valid_sort = 1'b1;
    np = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 2) tas = {N{3'd7}};
      if (i == 4) valid_sort = 1'b0;
      if (i == 6) valid_sort = 1'b1;
      if (knn_valid) begin
        np++;
        chk("busy_class", class_out, 3);
        chk("busy_count", vote_count, 3);
      end
    end
    chk("busy_pulses", np, 1);
    valid_sort = 1'b0;
    tick();

    // Abort at edge 3 of a vote.
    load('{6, 6, 6, 6, 6});
    valid_sort = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    #1;
    chk("abort_class", class_out, 0);
    chk("abort_count", vote_count, 0);
    chk("abort_valid", knn_valid, 0);
    chk("abort_busy", busy, 0);
    valid_sort = 1'b0;
    #2;
    rst = 1'b1;
    np = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (knn_valid) np++;
    end
    chk("abort_nopulse", np, 0);
    do_vote('{1, 1, 1, 2, 2}, "post_abort");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/knn_vote.md
Name: knn_vote

Overview:
- Downstream stage of distance_sort in the KNN system.
- Takes the distance-sorted type array and latches the K nearest type labels when a sort completes.
- Counts class occurrences sequentially, then scans the counts for the majority class.
- Emits the classification result with a one-cycle valid pulse; this block is the final decision stage of the classifier.

Parameters:
- N, 100, number of entries in the sorted arrays
- K, 5, number of nearest neighbours voted; legal range 1..N
- TYPE_W, 3, width of a type label; number of classes C = 2^TYPE_W; label 0 means "no class"
- CW, $clog2(K+1), width of the vote counters

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- valid_sort  input  1  sort-complete flag from distance_sort; level signal, rising edge starts a vote
- type_array_sorted  input  TYPE_W x N array  sorted type labels, index 0 = nearest
- class_out  output  TYPE_W  winning class, registered
- vote_count  output  CW  number of votes for class_out, registered
- knn_valid  output  1  one-cycle pulse; class_out and vote_count are valid
- busy  output  1  high from start acceptance until the cycle knn_valid is high, inclusive

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; class_out=0, vote_count=0, knn_valid=0, busy=0.
  - All per-class counters, first-index registers and the latched labels are cleared.
  - The valid_sort edge-detect register is cleared to 0.
- Start condition: in IDLE, valid_sort=1 sampled while the previous sample was 0.
  - A start is not accepted in any other state.
  - valid_sort held high does not retrigger; it must return low before the next vote.
- On the start edge (call it edge 0):
  - Latch type_array_sorted[0..K-1] into internal registers; later input changes have no effect on this vote.
  - Clear all C counters and first-index registers; set busy=1; state goes to COUNT.
- COUNT, edges 1..K: one latched entry i (i = 0..K-1) is processed per edge.
  - If label L != 0: cnt[L] increments, and first[L]=i if cnt[L] was 0.
  - Label 0 is skipped; it never counts.
  - Counters saturate at K, so they cannot overflow.
- SCAN, edges K+1..K+C: one class c is checked per edge, for c = 1..C-1 (slot c=0 is an idle compare).
  - best is replaced when cnt[c] > best_cnt.
  - On a tie (cnt[c] == best_cnt, and nonzero), best is replaced only if first[c] < first[best]. The tie goes to the class with the nearest neighbour.
  - best_cnt initialises to 0 and best to 0.
- DONE, edge K+C+1:
  - class_out=best and vote_count=best_cnt; knn_valid=1 for exactly one cycle.
  - Next edge: knn_valid=0, busy=0, state=IDLE.
- Latency: K+C+1 clock edges from start sample to knn_valid high. With the defaults this is 14.
- Hold behaviour: class_out and vote_count hold their values until the next DONE or a reset.
- All K labels 0: class_out=0, vote_count=0, knn_valid still pulses.
- valid_sort pulses while busy are ignored and not queued.
- Reset mid-operation: the block aborts immediately and the reset values apply. No knn_valid is issued for the aborted vote; the next rising edge of valid_sort after reset release starts a clean vote.
- K=1: class_out=type_array_sorted[0] and vote_count=1, unless that label is 0.

Test Plan:
- Reset check: assert rst=0 mid-simulation -> class_out=0, vote_count=0, knn_valid=0, busy=0 within the same cycle (asynchronous).
- Majority vote: sorted labels [3,3,1,2,3,...], rising valid_sort -> class_out=3, vote_count=3. knn_valid pulses exactly 14 cycles after the start edge, for one cycle; busy is high for 15 cycles.
- Tie-break: labels [2,4,4,2,5] -> class_out=2, vote_count=2 (class 2 first seen at index 0 vs class 4 at index 1). Then labels [4,2,2,4,1] -> class_out=4.
- Zero labels: labels [0,0,0,0,0] -> class_out=0, vote_count=0, knn_valid still pulses. Labels [0,0,5,0,1] -> class_out=5, vote_count=1.
- Handshake: valid_sort held high for 40 cycles -> exactly one knn_valid. A second rising edge of valid_sort during busy -> ignored. Modify type_array_sorted during COUNT -> result is unchanged.
- Reset mid-COUNT: pulse rst=0 at edge 3 of a vote -> no knn_valid for that vote. A new vote with labels [1,1,1,2,2] -> class_out=1, vote_count=3.
